// File: rtl/dec_tbl.sv
// Run-time-loadable symbol decode table with valid/ready handshaking on both sides.
// Optional saturating miss counter is enabled by defining DEC_TBL_MISS_CNT_EN.
module dec_tbl #(
    parameter int unsigned NBIT = 8
`ifdef DEC_TBL_MISS_CNT_EN
    , parameter int unsigned MISS_W = 16
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_clr,
    input  logic            cfg_we,
    input  logic [NBIT:0]   cfg_addr,
    input  logic [NBIT:0]   cfg_data,
    input  logic            cfg_vld,
    output logic            cfg_busy,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NBIT:0]   enc_s,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NBIT:0]   dec_s,
    output logic            dec_hit
`ifdef DEC_TBL_MISS_CNT_EN
    , output logic [MISS_W-1:0] miss_cnt
`endif
);

    localparam int unsigned W     = NBIT + 1;
    localparam int unsigned DEPTH = 1 << W;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]   state;
    logic [W-1:0] init_cnt;
    logic [W:0]   mem [DEPTH];
    logic [W:0]   rd_word;
    logic         accept;

    assign rd_word  = mem[enc_s];
    assign cfg_busy = (state == ST_INIT);
    assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else if (cfg_clr) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == '1) begin
                state <= ST_RUN;
            end
        end
    end

    // No reset on the array itself: INIT sweeps every entry after any reset.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[init_cnt] <= '0;
        end else if (cfg_we) begin
            mem[cfg_addr] <= {cfg_vld, cfg_data & {W{cfg_vld}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dec_s     <= '0;
            dec_hit   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            dec_s     <= rd_word[W-1:0];
            dec_hit   <= rd_word[W];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DEC_TBL_MISS_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cnt <= '0;
        end else if (cfg_clr) begin
            miss_cnt <= '0;
        end else if (accept && !rd_word[W] && (miss_cnt != '1)) begin
            miss_cnt <= miss_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dec_tbl.sv
// Self-checking bench for dec_tbl: directed scenarios plus a randomized run
// against an array-based reference model of the decode table.
module tb_dec_tbl;

    localparam int NBIT  = 8;
    localparam int W     = NBIT + 1;
    localparam int DEPTH = 1 << W;
`ifdef DEC_TBL_MISS_CNT_EN
    localparam int MISS_W   = 4;
    localparam int MISS_MAX = 15;
`else
    localparam int MISS_MAX = 65535;
`endif

    logic         clk;
    logic         rst_n;
    logic         cfg_clr;
    logic         cfg_we;
    logic [W-1:0] cfg_addr;
    logic [W-1:0] cfg_data;
    logic         cfg_vld;
    logic         cfg_busy;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] enc_s;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] dec_s;
    logic         dec_hit;
`ifdef DEC_TBL_MISS_CNT_EN
    logic [MISS_W-1:0] miss_cnt;
`endif

    dec_tbl #(
        .NBIT(NBIT)
`ifdef DEC_TBL_MISS_CNT_EN
        , .MISS_W(MISS_W)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_clr(cfg_clr), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_vld(cfg_vld),
        .cfg_busy(cfg_busy), .in_valid(in_valid), .in_ready(in_ready),
        .enc_s(enc_s), .out_valid(out_valid), .out_ready(out_ready),
        .dec_s(dec_s), .dec_hit(dec_hit)
`ifdef DEC_TBL_MISS_CNT_EN
        , .miss_cnt(miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: code book as plain arrays, INIT as a remaining-cycle count.
    bit           m_tbl_hit [DEPTH];
    logic [W-1:0] m_tbl_dat [DEPTH];
    bit           m_busy;
    int           m_left;
    bit           m_ov;
    logic [W-1:0] m_dec;
    bit           m_hit;
    int           m_miss;

    function automatic bit m_rdy();
        return !m_busy && (!m_ov || out_ready);
    endfunction

    task automatic model_clear_table();
        for (int i = 0; i < DEPTH; i++) begin
            m_tbl_hit[i] = 1'b0;
            m_tbl_dat[i] = '0;
        end
    endtask

    task automatic model_reset();
        model_clear_table();
        m_busy = 1'b1;
        m_left = DEPTH;
        m_ov   = 1'b0;
        m_dec  = '0;
        m_hit  = 1'b0;
        m_miss = 0;
    endtask

    task automatic idle_inputs();
        cfg_clr = 0; cfg_we = 0; cfg_addr = '0; cfg_data = '0; cfg_vld = 0;
        in_valid = 0; enc_s = '0; out_ready = 1;
    endtask

    // One clock edge; the model consumes the inputs present at that edge.
    task automatic tick();
        bit acc;
        @(posedge clk);
        acc = in_valid && m_rdy();
        if (acc) begin
            m_ov  = 1'b1;
            m_dec = m_tbl_dat[enc_s];
            m_hit = m_tbl_hit[enc_s];
            if (!m_hit && m_miss < MISS_MAX) m_miss++;
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        if (cfg_we && !m_busy) begin
            m_tbl_hit[cfg_addr] = cfg_vld;
            m_tbl_dat[cfg_addr] = cfg_vld ? cfg_data : '0;
        end
        if (cfg_clr) begin
            m_busy = 1'b1;
            m_left = DEPTH;
            m_miss = 0;
            model_clear_table();
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) m_busy = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (dec_s !== '0) begin errors++; $display("FAIL reset_dec_s got=%0d exp=0", dec_s); end
        checks++; if (dec_hit !== 1'b0) begin errors++; $display("FAIL reset_dec_hit got=%0b exp=0", dec_hit); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
        checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL reset_cfg_busy got=%0b exp=1", cfg_busy); end
`ifdef DEC_TBL_MISS_CNT_EN
        checks++; if (miss_cnt !== '0) begin errors++; $display("FAIL reset_miss_cnt got=%0d exp=0", miss_cnt); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (cfg_busy !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("FAIL init_busy cycle=%0d busy=%0b ready=%0b exp busy=1 ready=0", i, cfg_busy, in_ready);
            end
            tick();
        end
        checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL init_done_busy got=%0b exp=0", cfg_busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL init_done_ready got=%0b exp=1", in_ready); end
        in_valid = 1; enc_s = 9'd256;
        tick();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1 || dec_s !== 9'd0 || dec_hit !== 1'b0) begin
            errors++; $display("FAIL first_miss got v=%0b s=%0d h=%0b exp v=1 s=0 h=0", out_valid, dec_s, dec_hit); end
`ifdef DEC_TBL_MISS_CNT_EN
        checks++; if (miss_cnt !== 4'd1) begin errors++; $display("FAIL first_miss_cnt got=%0d exp=1", miss_cnt); end
`endif
        tick();
    endtask

    task automatic test_stream();
        logic [W-1:0] addrs [3];
        logic [W-1:0] vals  [3];
        addrs = '{9'd256, 9'd128, 9'd448};
        vals  = '{9'd1, 9'd2, 9'd7};
        for (int i = 0; i < 3; i++) begin
            cfg_we = 1; cfg_vld = 1; cfg_addr = addrs[i]; cfg_data = vals[i];
            tick();
        end
        cfg_we = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; enc_s = addrs[i];
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready idx=%0d got=%0b exp=1", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || dec_s !== vals[i] || dec_hit !== 1'b1) begin
                errors++; $display("FAIL stream_out idx=%0d got v=%0b s=%0d h=%0b exp v=1 s=%0d h=1", i, out_valid, dec_s, dec_hit, vals[i]); end
        end
        in_valid = 0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        in_valid = 1; enc_s = 9'd128; out_ready = 1;
        tick();
        enc_s = 9'd448; out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready cycle=%0d got=%0b exp=0", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || dec_s !== 9'd2 || dec_hit !== 1'b1) begin
                errors++; $display("FAIL bp_hold cycle=%0d got v=%0b s=%0d h=%0b exp v=1 s=2 h=1", i, out_valid, dec_s, dec_hit); end
        end
        out_ready = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%0b exp=1", in_ready); end
        tick();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1 || dec_s !== 9'd7) begin
            errors++; $display("FAIL bp_next got v=%0b s=%0d exp v=1 s=7", out_valid, dec_s); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_read_before_write();
        cfg_we = 1; cfg_vld = 1; cfg_addr = 9'd384; cfg_data = 9'd3;
        in_valid = 1; enc_s = 9'd384;
        tick();
        cfg_we = 0;
        checks++; if (dec_hit !== 1'b0 || dec_s !== 9'd0) begin
            errors++; $display("FAIL rbw_first got s=%0d h=%0b exp s=0 h=0", dec_s, dec_hit); end
        tick();
        in_valid = 0;
        checks++; if (dec_hit !== 1'b1 || dec_s !== 9'd3) begin
            errors++; $display("FAIL rbw_repeat got s=%0d h=%0b exp s=3 h=1", dec_s, dec_hit); end
        cfg_we = 1; cfg_vld = 0; cfg_addr = 9'd384; cfg_data = 9'd5;
        tick();
        cfg_we = 0; in_valid = 1; enc_s = 9'd384;
        tick();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1 || dec_hit !== 1'b0 || dec_s !== 9'd0) begin
            errors++; $display("FAIL rbw_invalidated got v=%0b s=%0d h=%0b exp v=1 s=0 h=0", out_valid, dec_s, dec_hit); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cfg_we    = ($urandom_range(0, 3) == 0);
            cfg_vld   = ($urandom_range(0, 4) != 0);
            cfg_addr  = W'($urandom_range(0, 15) * 32);
            cfg_data  = W'($urandom_range(0, DEPTH - 1));
            in_valid  = ($urandom_range(0, 3) != 0);
            enc_s     = W'($urandom_range(0, 15) * 32);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++; if (in_ready !== m_rdy()) begin errors++; $display("FAIL rand_ready cycle=%0d got=%0b exp=%0b", i, in_ready, m_rdy()); end
            tick();
            checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL rand_valid cycle=%0d got=%0b exp=%0b", i, out_valid, m_ov); end
            if (m_ov) begin
                checks++; if (dec_s !== m_dec || dec_hit !== m_hit) begin
                    errors++; $display("FAIL rand_out cycle=%0d got s=%0d h=%0b exp s=%0d h=%0b", i, dec_s, dec_hit, m_dec, m_hit); end
            end
`ifdef DEC_TBL_MISS_CNT_EN
            checks++; if (miss_cnt !== MISS_W'(m_miss)) begin errors++; $display("FAIL rand_miss cycle=%0d got=%0d exp=%0d", i, miss_cnt, m_miss); end
`endif
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_clr_pending();
        int n;
        cfg_we = 1; cfg_vld = 1; cfg_addr = 9'd256; cfg_data = 9'd1;
        tick();
        cfg_we = 0; in_valid = 1; enc_s = 9'd256; out_ready = 0;
        tick();
        in_valid = 0; cfg_clr = 1;
        tick();
        cfg_clr = 0;
        checks++; if (out_valid !== 1'b1 || dec_s !== 9'd1 || dec_hit !== 1'b1) begin
            errors++; $display("FAIL clr_pending_held got v=%0b s=%0d h=%0b exp v=1 s=1 h=1", out_valid, dec_s, dec_hit); end
        checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL clr_busy got=%0b exp=1", cfg_busy); end
`ifdef DEC_TBL_MISS_CNT_EN
        checks++; if (miss_cnt !== '0) begin errors++; $display("FAIL clr_miss_cleared got=%0d exp=0", miss_cnt); end
`endif
        out_ready = 1; in_valid = 1; enc_s = 9'd256;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clr_ready_init got=%0b exp=0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_drained got=%0b exp=0", out_valid); end
        for (int i = 0; i < 99; i++) tick();
        cfg_clr = 1;
        tick();
        cfg_clr = 0;
        n = 0;
        while (cfg_busy === 1'b1 && n < 2000) begin
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++; $display("FAIL clr_init_idle cycle=%0d got ready=%0b v=%0b exp 0 0", n, in_ready, out_valid); end
            tick();
            n++;
        end
        checks++; if (n != DEPTH) begin errors++; $display("FAIL clr_restart_len got=%0d exp=%0d", n, DEPTH); end
        tick();
        enc_s = 9'd448;
        checks++; if (out_valid !== 1'b1 || dec_hit !== 1'b0 || dec_s !== 9'd0) begin
            errors++; $display("FAIL clr_lookup_256 got v=%0b s=%0d h=%0b exp v=1 s=0 h=0", out_valid, dec_s, dec_hit); end
        tick();
        in_valid = 0;
        checks++; if (dec_hit !== 1'b0 || dec_s !== 9'd0) begin
            errors++; $display("FAIL clr_lookup_448 got s=%0d h=%0b exp s=0 h=0", dec_s, dec_hit); end
`ifdef DEC_TBL_MISS_CNT_EN
        checks++; if (miss_cnt !== 4'd2) begin errors++; $display("FAIL clr_miss_restart got=%0d exp=2", miss_cnt); end
`endif
        tick();
    endtask

`ifdef DEC_TBL_MISS_CNT_EN
    task automatic test_saturate();
        in_valid = 1; out_ready = 1;
        for (int i = 0; i < 20; i++) begin
            enc_s = W'($urandom_range(0, DEPTH - 1));
            tick();
            checks++; if (miss_cnt !== MISS_W'(m_miss)) begin errors++; $display("FAIL sat_step idx=%0d got=%0d exp=%0d", i, miss_cnt, m_miss); end
        end
        in_valid = 0;
        checks++; if (miss_cnt !== 4'd15) begin errors++; $display("FAIL sat_final got=%0d exp=15", miss_cnt); end
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        int n;
        in_valid = 1; enc_s = 9'd77; out_ready = 0;
        tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (out_valid !== 1'b0 || dec_s !== '0 || dec_hit !== 1'b0) begin
            errors++; $display("FAIL rstmid_out got v=%0b s=%0d h=%0b exp 0 0 0", out_valid, dec_s, dec_hit); end
        checks++; if (cfg_busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_ctrl got busy=%0b ready=%0b exp 1 0", cfg_busy, in_ready); end
`ifdef DEC_TBL_MISS_CNT_EN
        checks++; if (miss_cnt !== '0) begin errors++; $display("FAIL rstmid_miss got=%0d exp=0", miss_cnt); end
`endif
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (cfg_busy === 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        checks++; if (n != DEPTH) begin errors++; $display("FAIL rstmid_init_len got=%0d exp=%0d", n, DEPTH); end
        in_valid = 1; enc_s = 9'd128;
        tick();
        in_valid = 0;
        checks++; if (dec_hit !== 1'b0 || dec_s !== 9'd0) begin
            errors++; $display("FAIL rstmid_forgot got s=%0d h=%0b exp s=0 h=0", dec_s, dec_hit); end
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_read_before_write();
        test_random();
        test_clr_pending();
`ifdef DEC_TBL_MISS_CNT_EN
        test_saturate();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
